// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives a combinational ROM and presents one registered
// instruction per cycle to decode. Define FETCH_HALT_DETECT_EN to compile in halt-word detection.
module fetch_sequencer #(
   parameter int                ADDR_W    = 10,
   parameter int                DATA_W    = 10,
   parameter logic [ADDR_W-1:0] START_PC  = 10'd1,
   parameter logic [DATA_W-1:0] HALT_WORD = 10'b0010000010
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              busy,
   output logic              halted
);

`ifdef FETCH_HALT_DETECT_EN
   localparam logic HALT_EN = 1'b1;
`else
   localparam logic HALT_EN = 1'b0;
`endif

   localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
   logic              instr_valid_q, instr_valid_d;
   logic              busy_q, busy_d;
   logic              halted_q, halted_d;
   logic              fetch_s;
   logic              halt_hit_s;

   assign fetch_s    = (!instr_valid_q || instr_ready) && !redirect_valid;
   assign halt_hit_s = HALT_EN && (rom_data == HALT_WORD);

   // Next-state, next-pc and instruction-register update
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               pc_d          = START_PC;
               instr_valid_d = 1'b0;
               state_d       = ST_RUN;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (redirect_valid) begin
               pc_d          = redirect_addr;
               instr_valid_d = 1'b0;
               state_d       = ST_RUN;
            end else if (fetch_s) begin
               instr_d       = rom_data;
               instr_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               pc_d          = pc_q + PC_ONE;
               if (halt_hit_s) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            // The halt word still has to be handed to decode before stopping.
            if (redirect_valid) begin
               pc_d          = redirect_addr;
               instr_valid_d = 1'b0;
               state_d       = ST_RUN;
            end else if (instr_valid_q && instr_ready) begin
               instr_valid_d = 1'b0;
               state_d       = ST_HALT;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d       = ST_IDLE;
            instr_valid_d = 1'b0;
         end
      endcase
      busy_d   = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      halted_d = (state_d == ST_HALT);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         pc_q          <= START_PC;
         instr_q       <= {DATA_W{1'b0}};
         instr_pc_q    <= {ADDR_W{1'b0}};
         instr_valid_q <= 1'b0;
         busy_q        <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         busy_q        <= busy_d;
         halted_q      <= halted_d;
      end
   end

   assign rom_addr    = pc_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign busy        = busy_q;
   assign halted      = halted_q;

endmodule
